fighter_action_ctrl: RTL and testbench

- Per-player action sequencer for the two-player fighting game; one instance per player.
- Consumes per-key "held" flags from the USB keycode decoder and a once-per-frame tick, and sequences walk/crouch/jump/attack/hit-stun with frame-accurate timers.
- Drives the sprite-select, position-update and hit-detection logic with registered action state.

---
 rtl/fighter_pkg.sv | 37 +++
 rtl/fighter_action_ctrl_key_edge_sampler.sv | 28 ++
 rtl/fighter_action_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_fighter_action_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
// Shared types and default frame timing for the per-player action sequencer.
// Optional feature macro used by fighter_action_ctrl: COMBO_BUFFER_EN.
package fighter_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      WALK_L   = 4'd1,
      WALK_R   = 4'd2,
      CROUCH   = 4'd3,
      JUMP     = 4'd4,
      ATK_WIND = 4'd5,
      ATK_ACT  = 4'd6,
      ATK_REC  = 4'd7,
      STUN     = 4'd8
   } action_t;

   localparam logic KIND_PUNCH = 1'b0;
   localparam logic KIND_KICK  = 1'b1;

   localparam int DEF_JUMP_FRAMES = 16;
   localparam int DEF_ATK_WINDUP  = 3;
   localparam int DEF_ATK_ACTIVE  = 4;
   localparam int DEF_KICK_EXTRA  = 2;
   localparam int DEF_ATK_RECOVER = 8;
   localparam int DEF_STUN_FRAMES = 12;
   localparam int DEF_CW          = 6;

   // Bit positions inside the packed key vector.
   localparam int NKEYS   = 6;
   localparam int K_LEFT  = 0;
   localparam int K_RIGHT = 1;
   localparam int K_UP    = 2;
   localparam int K_DOWN  = 3;
   localparam int K_PUNCH = 4;
   localparam int K_KICK  = 5;

endpackage

// File: rtl/fighter_action_ctrl_key_edge_sampler.sv
// Captures the key flags on every enabled frame tick and reports which keys
// are held now and which went from released to held since the last tick.
module key_edge_sampler
   import fighter_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             sample_i,
   input  logic [NKEYS-1:0] keys_i,
   output logic [NKEYS-1:0] held_o,
   output logic [NKEYS-1:0] pressed_o
);

   logic [NKEYS-1:0] prev_q;

   // Remember the key snapshot taken at the previous enabled tick.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         prev_q <= '0;
      end else if (sample_i) begin
         prev_q <= keys_i;
      end
   end

   assign held_o    = keys_i;
   assign pressed_o = keys_i & ~prev_q;

endmodule

// File: rtl/fighter_action_ctrl.sv
// Per-player action sequencer: walk / crouch / jump / attack / hit-stun with
// frame-accurate timers. All state advances only on frame_tick && enable.
// Optional feature: define COMBO_BUFFER_EN to buffer an attack press made
// during recovery and chain straight into a new windup.
// The current state is exposed on the action output.
module fighter_action_ctrl
   import fighter_pkg::*;
#(
   parameter int JUMP_FRAMES = DEF_JUMP_FRAMES,
   parameter int ATK_WINDUP  = DEF_ATK_WINDUP,
   parameter int ATK_ACTIVE  = DEF_ATK_ACTIVE,
   parameter int KICK_EXTRA  = DEF_KICK_EXTRA,
   parameter int ATK_RECOVER = DEF_ATK_RECOVER,
   parameter int STUN_FRAMES = DEF_STUN_FRAMES,
   parameter int CW          = DEF_CW
)(
   input  logic          Clk,
   input  logic          Reset,
   input  logic          frame_tick,
   input  logic          enable,
   input  logic          left_on,
   input  logic          right_on,
   input  logic          up_on,
   input  logic          down_on,
   input  logic          punch_on,
   input  logic          kick_on,
   input  logic          hit_in,
   output logic [3:0]    action,
   output logic          move_l,
   output logic          move_r,
   output logic          facing,
   output logic [CW-1:0] jump_h,
   output logic          atk_active,
   output logic          atk_kind,
   output logic          busy
);

   localparam logic [CW-1:0] T_ONE    = CW'(1);
   localparam logic [CW-1:0] T_JUMP   = CW'(JUMP_FRAMES);
   localparam logic [CW-1:0] T_HALF   = CW'(JUMP_FRAMES / 2);
   localparam logic [CW-1:0] T_WIND   = CW'(ATK_WINDUP);
   localparam logic [CW-1:0] T_ACT_P  = CW'(ATK_ACTIVE);
   localparam logic [CW-1:0] T_ACT_K  = CW'(ATK_ACTIVE + KICK_EXTRA);
   localparam logic [CW-1:0] T_REC    = CW'(ATK_RECOVER);
   localparam logic [CW-1:0] T_STUN   = CW'(STUN_FRAMES);

   logic             step;
   logic             hit_now;
   logic [NKEYS-1:0] keys, held, pressed;
   logic             unused_keys;

   action_t          act_q, act_d;
   logic [CW-1:0]    timer_q, timer_d;
   logic [CW-1:0]    jump_h_q, jump_h_d;
   logic [CW-1:0]    elapsed;
   logic             facing_q, facing_d;
   logic             kind_q, kind_d;
   logic             move_l_q, move_l_d;
   logic             move_r_q, move_r_d;
   logic             atk_active_q, atk_active_d;
   logic             busy_q, busy_d;
   logic             hit_pend_q, hit_pend_d;
`ifdef COMBO_BUFFER_EN
   logic             buf_v_q, buf_v_d;
   logic             buf_k_q, buf_k_d;
`endif

   assign step    = frame_tick & enable;
   assign hit_now = hit_pend_q | hit_in;
   assign keys    = {kick_on, punch_on, down_on, up_on, right_on, left_on};

   key_edge_sampler u_keys (
      .Clk       (Clk),
      .Reset     (Reset),
      .sample_i  (step),
      .keys_i    (keys),
      .held_o    (held),
      .pressed_o (pressed)
   );

   // Attacks and jump are edge-triggered; the remaining bits are not needed.
   assign unused_keys = ^{held[K_PUNCH], held[K_KICK], held[K_UP],
                          pressed[K_LEFT], pressed[K_RIGHT], pressed[K_DOWN]};

   // Next state, timer and registered outputs, evaluated once per enabled tick.
   always_comb begin
      act_d        = act_q;
      timer_d      = timer_q;
      facing_d     = facing_q;
      kind_d       = kind_q;
      move_l_d     = move_l_q;
      move_r_d     = move_r_q;
      jump_h_d     = jump_h_q;
      atk_active_d = atk_active_q;
      busy_d       = busy_q;
      hit_pend_d   = hit_pend_q | hit_in;
      elapsed      = '0;
`ifdef COMBO_BUFFER_EN
      buf_v_d      = buf_v_q;
      buf_k_d      = buf_k_q;
`endif
      if (step) begin
         hit_pend_d = 1'b0;
         if (hit_now) begin
            act_d   = STUN;
            timer_d = T_STUN;
`ifdef COMBO_BUFFER_EN
            buf_v_d = 1'b0;
`endif
         end else begin
            case (act_q)
               IDLE, WALK_L, WALK_R, CROUCH: begin
                  timer_d = '0;
                  if (pressed[K_PUNCH]) begin
                     act_d   = ATK_WIND;
                     timer_d = T_WIND;
                     kind_d  = KIND_PUNCH;
                  end else if (pressed[K_KICK]) begin
                     act_d   = ATK_WIND;
                     timer_d = T_WIND;
                     kind_d  = KIND_KICK;
                  end else if (pressed[K_UP]) begin
                     act_d   = JUMP;
                     timer_d = T_JUMP;
                  end else if (held[K_DOWN]) begin
                     act_d = CROUCH;
                  end else if (held[K_LEFT] && !held[K_RIGHT]) begin
                     act_d    = WALK_L;
                     facing_d = 1'b1;
                  end else if (held[K_RIGHT] && !held[K_LEFT]) begin
                     act_d    = WALK_R;
                     facing_d = 1'b0;
                  end else begin
                     act_d = IDLE;
                  end
               end
               ATK_WIND: begin
                  if (timer_q <= T_ONE) begin
                     act_d   = ATK_ACT;
                     timer_d = kind_q ? T_ACT_K : T_ACT_P;
                  end else begin
                     timer_d = timer_q - T_ONE;
                  end
               end
               ATK_ACT: begin
                  if (timer_q <= T_ONE) begin
                     act_d   = ATK_REC;
                     timer_d = T_REC;
                  end else begin
                     timer_d = timer_q - T_ONE;
                  end
               end
               ATK_REC: begin
`ifdef COMBO_BUFFER_EN
                  if (pressed[K_PUNCH]) begin
                     buf_v_d = 1'b1;
                     buf_k_d = KIND_PUNCH;
                  end else if (pressed[K_KICK]) begin
                     buf_v_d = 1'b1;
                     buf_k_d = KIND_KICK;
                  end
                  if (timer_q <= T_ONE) begin
                     if (buf_v_d) begin
                        act_d   = ATK_WIND;
                        timer_d = T_WIND;
                        kind_d  = buf_k_d;
                     end else begin
                        act_d   = IDLE;
                        timer_d = '0;
                     end
                     buf_v_d = 1'b0;
                  end else begin
                     timer_d = timer_q - T_ONE;
                  end
`else
                  if (timer_q <= T_ONE) begin
                     act_d   = IDLE;
                     timer_d = '0;
                  end else begin
                     timer_d = timer_q - T_ONE;
                  end
`endif
               end
               JUMP, STUN: begin
                  if (timer_q <= T_ONE) begin
                     act_d   = IDLE;
                     timer_d = '0;
                  end else begin
                     timer_d = timer_q - T_ONE;
                  end
               end
               default: begin
                  act_d   = IDLE;
                  timer_d = '0;
               end
            endcase
         end
         // Airborne: height rises one unit per frame, then falls symmetrically.
         elapsed      = T_JUMP - timer_d + T_ONE;
         jump_h_d     = (act_d == JUMP) ? ((elapsed <= T_HALF) ? elapsed : T_JUMP - elapsed) : '0;
         move_l_d     = (act_d == WALK_L) || ((act_d == JUMP) && held[K_LEFT]);
         move_r_d     = (act_d == WALK_R) || ((act_d == JUMP) && held[K_RIGHT]);
         atk_active_d = (act_d == ATK_ACT);
         busy_d       = (act_d == JUMP) || (act_d == ATK_WIND) || (act_d == ATK_ACT) ||
                        (act_d == ATK_REC) || (act_d == STUN);
      end
   end

   // State register; reset overrides any tick or pending hit on the same edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         act_q        <= IDLE;
         timer_q      <= '0;
         facing_q     <= 1'b0;
         kind_q       <= KIND_PUNCH;
         move_l_q     <= 1'b0;
         move_r_q     <= 1'b0;
         jump_h_q     <= '0;
         atk_active_q <= 1'b0;
         busy_q       <= 1'b0;
         hit_pend_q   <= 1'b0;
`ifdef COMBO_BUFFER_EN
         buf_v_q      <= 1'b0;
         buf_k_q      <= KIND_PUNCH;
`endif
      end else begin
         act_q        <= act_d;
         timer_q      <= timer_d;
         facing_q     <= facing_d;
         kind_q       <= kind_d;
         move_l_q     <= move_l_d;
         move_r_q     <= move_r_d;
         jump_h_q     <= jump_h_d;
         atk_active_q <= atk_active_d;
         busy_q       <= busy_d;
         hit_pend_q   <= hit_pend_d;
`ifdef COMBO_BUFFER_EN
         buf_v_q      <= buf_v_d;
         buf_k_q      <= buf_k_d;
`endif
      end
   end

   assign action     = act_q;
   assign move_l     = move_l_q;
   assign move_r     = move_r_q;
   assign facing     = facing_q;
   assign jump_h     = jump_h_q;
   assign atk_active = atk_active_q;
   assign atk_kind   = kind_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_fighter_action_ctrl.sv
// Bench for fighter_action_ctrl: directed test-plan scenarios followed by
// random key/tick/hit traffic, checked against a frame-count reference model.
module tb_fighter_action_ctrl;
   import fighter_pkg::*;

   localparam int JF  = 16;
   localparam int WND = 3;
   localparam int ACT = 4;
   localparam int KEX = 2;
   localparam int RCV = 8;
   localparam int STN = 12;
   localparam int CW  = 6;
   localparam int OW  = 4 + 3 + CW + 3;

   logic          Clk, Reset, frame_tick, enable;
   logic          left_on, right_on, up_on, down_on, punch_on, kick_on, hit_in;
   logic [3:0]    action;
   logic          move_l, move_r, facing, atk_active, atk_kind, busy;
   logic [CW-1:0] jump_h;

   fighter_action_ctrl #(
      .JUMP_FRAMES (JF), .ATK_WINDUP (WND), .ATK_ACTIVE (ACT),
      .KICK_EXTRA  (KEX), .ATK_RECOVER (RCV), .STUN_FRAMES (STN), .CW (CW)
   ) dut (
      .Clk (Clk), .Reset (Reset), .frame_tick (frame_tick), .enable (enable),
      .left_on (left_on), .right_on (right_on), .up_on (up_on), .down_on (down_on),
      .punch_on (punch_on), .kick_on (kick_on), .hit_in (hit_in),
      .action (action), .move_l (move_l), .move_r (move_r), .facing (facing),
      .jump_h (jump_h), .atk_active (atk_active), .atk_kind (atk_kind), .busy (busy)
   );

   // ---------------- clock ----------------
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- reference model ----------------
   // mode: 0 free (IDLE/WALK/CROUCH), 1 attack, 2 jump, 3 stun.
   // el counts frames since the action began (0 on the entry frame).
   int         m_mode, m_el;
   logic [3:0] m_free;
   logic       m_face, m_kind, m_pend, m_ml, m_mr, m_buf_v, m_buf_k;
   logic [5:0] m_prev;

   logic [OW-1:0] exp_q[$];
   int            n_checks, n_pass, n_fail_prints;
   logic          running;

   function automatic int act_len(input logic k);
      return ACT + (k ? KEX : 0);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_el = 0; m_free = IDLE; m_face = 0; m_kind = 0;
      m_pend = 0; m_ml = 0; m_mr = 0; m_buf_v = 0; m_buf_k = 0; m_prev = '0;
   endtask

   task automatic start_attack(input logic k);
      m_mode = 1; m_el = 0; m_kind = k;
   endtask

   task automatic go_idle();
      m_mode = 0; m_free = IDLE;
   endtask

   task automatic model_tick();
      logic [5:0] keys, pr;
      logic       hit;
      keys   = {kick_on, punch_on, down_on, up_on, right_on, left_on};
      pr     = keys & ~m_prev;
      m_prev = keys;
      hit    = m_pend | hit_in;
      m_pend = 0;
      m_ml   = 0;
      m_mr   = 0;
      if (hit) begin
         m_mode = 3; m_el = 0; m_buf_v = 0;
      end else if (m_mode == 0) begin
         if (pr[4])                  start_attack(1'b0);
         else if (pr[5])             start_attack(1'b1);
         else if (pr[2]) begin
            m_mode = 2; m_el = 0; m_ml = keys[0]; m_mr = keys[1];
         end
         else if (keys[3])           m_free = CROUCH;
         else if (keys[0] ^ keys[1]) begin
            m_free = keys[0] ? WALK_L : WALK_R;
            m_face = keys[0];
         end
         else                        m_free = IDLE;
      end else if (m_mode == 1) begin
`ifdef COMBO_BUFFER_EN
         if (m_el >= WND + act_len(m_kind) && (pr[4] || pr[5])) begin
            m_buf_v = 1; m_buf_k = !pr[4];
         end
`endif
         m_el++;
         if (m_el == WND + act_len(m_kind) + RCV) begin
            if (m_buf_v) begin
               start_attack(m_buf_k); m_buf_v = 0;
            end else go_idle();
         end
      end else if (m_mode == 2) begin
         m_el++;
         if (m_el == JF) go_idle();
         else begin m_ml = keys[0]; m_mr = keys[1]; end
      end else begin
         m_el++;
         if (m_el == STN) go_idle();
      end
   endtask

   function automatic logic [OW-1:0] model_out();
      logic [3:0]    a;
      logic          ml, mr;
      logic [CW-1:0] h;
      int            e;
      a = m_free; ml = 0; mr = 0; h = '0;
      case (m_mode)
         0: begin ml = (m_free == WALK_L); mr = (m_free == WALK_R); end
         1: begin
            if (m_el < WND)                      a = ATK_WIND;
            else if (m_el < WND + act_len(m_kind)) a = ATK_ACT;
            else                                 a = ATK_REC;
         end
         2: begin
            a = JUMP; ml = m_ml; mr = m_mr;
            e = m_el + 1;
            h = CW'((e <= JF / 2) ? e : JF - e);
         end
         default: a = STUN;
      endcase
      return {a, ml, mr, m_face, h, (a == ATK_ACT), m_kind, (m_mode != 0)};
   endfunction

   // ---------------- driver ----------------
   // Inputs are set before the call; the expected post-edge outputs are queued,
   // then one clock edge is applied and single-cycle pulses are dropped.
   task automatic step();
      if (Reset)                         model_reset();
      else if (frame_tick && enable)     model_tick();
      else                               m_pend = m_pend | hit_in;
      exp_q.push_back(model_out());
      @(posedge Clk);
      #1;
      frame_tick = 0;
      hit_in     = 0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1;
         step();
         step();
      end
   endtask

   task automatic release_keys();
      {left_on, right_on, up_on, down_on, punch_on, kick_on} = '0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [OW-1:0] mon_act, mon_exp;
   always @(negedge Clk) begin
      if (running) begin
         mon_act = {action, move_l, move_r, facing, jump_h, atk_active, atk_kind, busy};
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_underflow t=%0t got %h required an expected entry", $time, mon_act);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act === mon_exp) n_pass++;
            else if (n_fail_prints < 40) begin
               n_fail_prints++;
               $display("FAIL outputs t=%0t got act=%0d ml=%b mr=%b f=%b h=%0d aa=%b k=%b b=%b required act=%0d ml=%b mr=%b f=%b h=%0d aa=%b k=%b b=%b",
                        $time, mon_act[OW-1 -: 4], mon_act[OW-5], mon_act[OW-6], mon_act[OW-7],
                        mon_act[CW+2:3], mon_act[2], mon_act[1], mon_act[0],
                        mon_exp[OW-1 -: 4], mon_exp[OW-5], mon_exp[OW-6], mon_exp[OW-7],
                        mon_exp[CW+2:3], mon_exp[2], mon_exp[1], mon_exp[0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0; n_pass = 0; n_fail_prints = 0;
      Reset = 1; frame_tick = 0; enable = 1; hit_in = 0;
      release_keys();
      model_reset();
      running = 1;
      step(); step();
      Reset = 0;
      step();

      // walk right, then both horizontal keys cancel to IDLE
      right_on = 1; ticks(3);
      left_on = 1;  ticks(1);
      release_keys(); ticks(1);

      // held punch: single attack, no retrigger
      punch_on = 1; ticks(20);
      release_keys(); ticks(1);

      // kick, then punch+kick on the same frame
      kick_on = 1; ticks(1); release_keys(); ticks(18);
      punch_on = 1; kick_on = 1; ticks(1); release_keys(); ticks(16);

      // jump with air control and an ignored punch
      up_on = 1; ticks(1); up_on = 0; ticks(4);
      left_on = 1; ticks(2);
      punch_on = 1; ticks(1); punch_on = 0; ticks(5);
      left_on = 0; ticks(6);

      // hit between ticks during the active window
      punch_on = 1; ticks(1); punch_on = 0; ticks(4);
      hit_in = 1; step();
      ticks(13);

      // pending hit survives a 5-tick pause
      punch_on = 1; ticks(1); punch_on = 0; ticks(2);
      enable = 0; hit_in = 1; step(); ticks(5);
      enable = 1; ticks(14);

      // press during recovery (chains only when the combo buffer exists)
      punch_on = 1; ticks(1); punch_on = 0; ticks(9);
      kick_on = 1; ticks(1); kick_on = 0; ticks(25);

      // reset mid-action wins over tick and hit
      punch_on = 1; ticks(1); punch_on = 0; ticks(5);
      Reset = 1; frame_tick = 1; hit_in = 1; step();
      Reset = 0; ticks(3);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0) left_on  = ~left_on;
         if ($urandom_range(0, 15) == 0) right_on = ~right_on;
         if ($urandom_range(0, 23) == 0) up_on    = ~up_on;
         if ($urandom_range(0, 23) == 0) down_on  = ~down_on;
         if ($urandom_range(0, 11) == 0) punch_on = ~punch_on;
         if ($urandom_range(0, 11) == 0) kick_on  = ~kick_on;
         frame_tick = ($urandom_range(0, 2) == 0);
         enable     = ($urandom_range(0, 9) != 0);
         hit_in     = ($urandom_range(0, 59) == 0);
         Reset      = ($urandom_range(0, 499) == 0);
         step();
         Reset = 0;
      end

      @(negedge Clk);
      #1;
      running = 0;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain got %0d entries left required 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
